// File: rtl/can_pkg.sv
// can_pkg: shared CAN constants, CRC-15 parameters and receive-checker state encoding
package can_pkg;
  localparam int CRC_W = 15;
  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;
  localparam int MAX_LEN = 83;
  typedef enum logic [2:0] {IDLE, DATA, CRCF, DELIM, REPORT} state_t;
endpackage

// File: rtl/can_crc.sv
// can_crc: bit-serial CAN CRC-15 generator, cleared by initialize, advanced by enable
module can_crc
  import can_pkg::*;
(
  input  logic             clk,
  input  logic             data,
  input  logic             enable,
  input  logic             initialize,
  output logic [CRC_W-1:0] crc
);
  logic nxt;
  assign nxt = data ^ crc[CRC_W-1];
  always_ff @(posedge clk)
    if (initialize) crc <= '0;
    else if (enable) crc <= {crc[CRC_W-2:0], 1'b0} ^ (nxt ? CRC_POLY : '0);
endmodule

// File: rtl/can_rx_crc_check.sv
// can_rx_crc_check: checks CRC-15 and delimiter of a destuffed CAN receive frame
module can_rx_crc_check
  import can_pkg::state_t, can_pkg::IDLE, can_pkg::DATA, can_pkg::CRCF, can_pkg::DELIM, can_pkg::REPORT;
#(
  parameter int MAX_LEN = can_pkg::MAX_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [6:0]  i_len,
  input  logic        i_bit,
  input  logic        i_bit_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_crc_ok,
  output logic        o_crc_err,
  output logic        o_form_err,
  output logic        o_len_err,
  output logic [14:0] o_calc_crc,
  output logic [14:0] o_rx_crc
);
  state_t state, state_d;
  logic [6:0] cnt;
  logic form_f, crc_f, len_f, len_bad, last;
  assign len_bad = (i_len == 7'd0) || (i_len > 7'(MAX_LEN));
  assign last = i_bit_valid && cnt == 7'd1;
  // reset also clears the generator, which has no reset of its own
  can_crc u_crc (
    .clk       (clk),
    .data      (i_bit),
    .enable    (state == DATA && i_bit_valid),
    .initialize(i_start || rst),
    .crc       (o_calc_crc)
  );
  always_comb begin
    state_d = state;
    case (state)
      DATA:    state_d = last ? CRCF : DATA;
      CRCF:    state_d = last ? DELIM : CRCF;
      DELIM:   state_d = i_bit_valid ? REPORT : DELIM;
      default: state_d = IDLE;
    endcase
    if (i_start) state_d = len_bad ? REPORT : DATA;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      o_rx_crc <= '0;
      form_f <= 1'b0;
      crc_f <= 1'b0;
      len_f <= 1'b0;
    end else if (i_start) begin
      cnt <= i_len;
      o_rx_crc <= '0;
      form_f <= 1'b0;
      crc_f <= 1'b0;
      len_f <= len_bad;
    end else if (i_bit_valid) begin
      if (state == DATA || state == CRCF) cnt <= (state == DATA && cnt == 7'd1) ? 7'd15 : cnt - 7'd1;
      if (state == CRCF) o_rx_crc <= {o_rx_crc[13:0], i_bit};
      if (state == DELIM) begin
        form_f <= ~i_bit;
        crc_f <= o_rx_crc != o_calc_crc;
      end
    end
  assign o_done = state == REPORT;
  assign o_busy = state == DATA || state == CRCF || state == DELIM;
  assign o_form_err = o_done & form_f;
  assign o_crc_err = o_done & crc_f;
  assign o_len_err = o_done & len_f;
  assign o_crc_ok = o_done & ~form_f & ~crc_f & ~len_f;
endmodule

// File: tb/tb_can_rx_crc_check.sv
// tb_can_rx_crc_check: directed self-checking bench with hand-computed CRC vectors
module tb_can_rx_crc_check;
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_bit = 1'b0, i_bit_valid = 1'b0;
  logic [6:0] i_len = '0;
  logic o_busy, o_done, o_crc_ok, o_crc_err, o_form_err, o_len_err;
  logic [14:0] o_calc_crc, o_rx_crc;
  int n_assert = 0, n_fail = 0, done_cnt = 0, d0;
  bit gaps = 0;

  can_rx_crc_check dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_bit(i_bit),
    .i_bit_valid(i_bit_valid), .o_busy(o_busy), .o_done(o_done), .o_crc_ok(o_crc_ok),
    .o_crc_err(o_crc_err), .o_form_err(o_form_err), .o_len_err(o_len_err),
    .o_calc_crc(o_calc_crc), .o_rx_crc(o_rx_crc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (o_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [6:0] len);
    i_start = 1'b1;
    i_len = len;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    if (gaps) repeat ($urandom_range(0, 5)) tick();
    i_bit = b;
    i_bit_valid = 1'b1;
    tick();
    i_bit_valid = 1'b0;
  endtask

  // bits[0] is the first covered bit; rx is sent MSB first
  task automatic frame(input logic [6:0] len, input logic [82:0] bits, input logic [14:0] rx, input logic delim);
    start(len);
    for (int i = 0; i < int'(len); i++) send_bit(bits[i]);
    for (int i = 14; i >= 0; i--) send_bit(rx[i]);
    send_bit(delim);
  endtask

  task automatic verdict(input string tag, input logic ok, input logic ce, input logic fe, input logic le);
    chk({tag, " done"}, 32'(o_done), 32'h1);
    chk({tag, " ok"}, 32'(o_crc_ok), 32'(ok));
    chk({tag, " crc_err"}, 32'(o_crc_err), 32'(ce));
    chk({tag, " form_err"}, 32'(o_form_err), 32'(fe));
    chk({tag, " len_err"}, 32'(o_len_err), 32'(le));
    chk({tag, " busy"}, 32'(o_busy), 32'h0);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("reset busy", 32'(o_busy), 32'h0);
    chk("reset done", 32'(o_done), 32'h0);
    chk("reset flags", {28'h0, o_crc_ok, o_crc_err, o_form_err, o_len_err}, 32'h0);
    chk("reset calc", 32'(o_calc_crc), 32'h0);
    chk("reset rx", 32'(o_rx_crc), 32'h0);

    start(7'd83);
    chk("busy after start", 32'(o_busy), 32'h1);
    for (int i = 0; i < 83; i++) send_bit(1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b0);
    send_bit(1'b1);
    verdict("zero83", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero83 calc", 32'(o_calc_crc), 32'h0);
    tick();
    chk("done one cycle", 32'(o_done), 32'h0);
    chk("flags zero idle", 32'(o_crc_ok), 32'h0);

    frame(7'd1, 83'h1, 15'h4599, 1'b1);
    verdict("one ok", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("one calc", 32'(o_calc_crc), 32'h4599);
    tick();
    frame(7'd1, 83'h1, 15'h4598, 1'b1);
    verdict("one bad", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("one bad rx", 32'(o_rx_crc), 32'h4598);
    tick();

    start(7'd2);
    send_bit(1'b1);
    chk("calc after bit1", 32'(o_calc_crc), 32'h4599);
    send_bit(1'b0);
    chk("calc after bit2", 32'(o_calc_crc), 32'h4EAB);
    for (int i = 14; i >= 0; i--) send_bit(1'(15'h4EAB >> i));
    chk("delim no done yet", 32'(o_done), 32'h0);
    send_bit(1'b1);
    verdict("two", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("two rx", 32'(o_rx_crc), 32'h4EAB);
    tick();
    chk("rx held", 32'(o_rx_crc), 32'h4EAB);

    frame(7'd2, 83'h1, 15'h4EAB, 1'b0);
    verdict("form", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    frame(7'd2, 83'h1, 15'h0001, 1'b0);
    verdict("form+crc", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();

    start(7'd0);
    verdict("len0", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    start(7'd84);
    verdict("len84", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    d0 = done_cnt;
    start(7'd83);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    i_bit = 1'b1;
    i_bit_valid = 1'b1;
    start(7'd2);
    i_bit_valid = 1'b0;
    chk("abort no done", 32'(done_cnt - d0), 32'h0);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 14; i >= 0; i--) send_bit(1'(15'h4EAB >> i));
    send_bit(1'b1);
    verdict("abort restart", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("abort one done", 32'(done_cnt - d0), 32'h1);

    gaps = 1;
    frame(7'd2, 83'h1, 15'h4EAB, 1'b1);
    gaps = 0;
    verdict("gapped", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("gapped calc", 32'(o_calc_crc), 32'h4EAB);
    tick();

    d0 = done_cnt;
    start(7'd2);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy", 32'(o_busy), 32'h0);
    chk("rst done", 32'(o_done), 32'h0);
    chk("rst calc", 32'(o_calc_crc), 32'h0);
    chk("rst rx", 32'(o_rx_crc), 32'h0);
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    chk("rst no done", 32'(done_cnt - d0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
